// File: rtl/crossover_gene_writer.sv
// Assembles one child genome by copying parent genes picked by a selector stream.
// Reads are one enabled cycle deep, so every copied gene costs RUN -> READ -> WRITE.
//   state   | meaning
//   S_IDLE  | waiting for start; child_size/err hold the last result
//   S_RUN   | sel_ready high, consuming one selector decision per enabled edge
//   S_READ  | parent address presented, waiting for read data
//   S_WRITE | child write pulse, advance child_size and source pointer
//   S_FIN   | one-cycle done pulse, then back to idle
module crossover_gene_writer #(
  parameter int GENE_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              start,
  input  logic [ADDR_W-1:0] genome1_size,
  input  logic [ADDR_W-1:0] genome2_size,
  input  logic [1:0]        sel,
  output logic              sel_ready,
  output logic [ADDR_W-1:0] g1_rd_addr,
  output logic [ADDR_W-1:0] g2_rd_addr,
  input  logic [GENE_W-1:0] g1_rd_data,
  input  logic [GENE_W-1:0] g2_rd_data,
  output logic              child_wr_en,
  output logic [ADDR_W-1:0] child_wr_addr,
  output logic [GENE_W-1:0] child_wr_data,
  output logic [ADDR_W-1:0] child_size,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_READ, S_WRITE, S_FIN} state_t;

  localparam logic [ADDR_W-1:0] SIZE_MAX = '1;
  localparam logic [ADDR_W-1:0] ONE      = 1;

  state_t            r_state, w_next_state;
  logic [ADDR_W-1:0] r_size1, r_size2, r_p1, r_p2, r_child_size;
  logic [ADDR_W-1:0] r_g1_addr, r_g2_addr;
  logic              r_src_g2, r_err;
  logic              w_rd1, w_rd2, w_sel_err, w_full, w_wr;

  assign w_full = (r_child_size == SIZE_MAX);

  always_ff @(posedge clk) begin
    if (!rst)    r_state <= S_IDLE;
    else if (ce) r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_rd1        = 1'b0;
    w_rd2        = 1'b0;
    w_sel_err    = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next_state = S_RUN;
      S_RUN: begin
        case (sel)
          2'b10: begin
            if (r_p1 < r_size1) begin w_rd1 = 1'b1; w_next_state = S_READ; end
            else begin w_sel_err = 1'b1; w_next_state = S_FIN; end
          end
          2'b11: begin
            if (r_p2 < r_size2) begin w_rd2 = 1'b1; w_next_state = S_READ; end
            else begin w_sel_err = 1'b1; w_next_state = S_FIN; end
          end
          2'b01:   w_next_state = S_FIN;
          default: w_next_state = S_RUN;
        endcase
      end
      S_READ:  w_next_state = S_WRITE;
      S_WRITE: w_next_state = w_full ? S_FIN : S_RUN;
      S_FIN:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_size1      <= '0;
      r_size2      <= '0;
      r_p1         <= '0;
      r_p2         <= '0;
      r_child_size <= '0;
      r_g1_addr    <= '0;
      r_g2_addr    <= '0;
      r_src_g2     <= 1'b0;
      r_err        <= 1'b0;
    end else if (ce) begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_size1      <= genome1_size;
            r_size2      <= genome2_size;
            r_p1         <= '0;
            r_p2         <= '0;
            r_child_size <= '0;
            r_err        <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_rd1) begin r_g1_addr <= r_p1; r_src_g2 <= 1'b0; end
          if (w_rd2) begin r_g2_addr <= r_p2; r_src_g2 <= 1'b1; end
          if (w_sel_err) r_err <= 1'b1;
        end
        S_WRITE: begin
          // The last slot is still written, but child_size saturates instead of wrapping.
          if (w_full) r_err <= 1'b1;
          else        r_child_size <= r_child_size + ONE;
          if (r_src_g2) r_p2 <= r_p2 + ONE;
          else          r_p1 <= r_p1 + ONE;
        end
        default: ;
      endcase
    end
  end

  // Gating with rst drops a write pulse the moment reset arrives mid-WRITE.
  assign w_wr          = (r_state == S_WRITE) && rst;
  assign child_wr_en   = w_wr;
  assign child_wr_addr = w_wr ? r_child_size : '0;
  assign child_wr_data = w_wr ? (r_src_g2 ? g2_rd_data : g1_rd_data) : '0;

  assign sel_ready  = (r_state == S_RUN);
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_FIN);
  assign err        = r_err;
  assign child_size = r_child_size;
  assign g1_rd_addr = r_g1_addr;
  assign g2_rd_addr = r_g2_addr;

endmodule

// File: tb/tb_crossover_gene_writer.sv
// Directed bench for crossover_gene_writer with clock-enabled parent memory models.
module tb_crossover_gene_writer;

  logic        clk = 1'b0;
  logic        rst, ce, start;
  logic [7:0]  genome1_size, genome2_size;
  logic [1:0]  sel;
  logic        sel_ready, child_wr_en, busy, done, err;
  logic [7:0]  g1_rd_addr, g2_rd_addr, child_wr_addr, child_size;
  logic [15:0] g1_rd_data, g2_rd_data, child_wr_data;

  logic [15:0] g1_mem [256];
  logic [15:0] g2_mem [256];
  logic [15:0] child_mem [256];
  int wr_cnt = 0, done_cnt = 0, rd_cnt = 0;
  int n_cmp = 0, n_bad = 0;
  int w0, d0, r0;

  always #5 clk = ~clk;

  crossover_gene_writer #(.GENE_W(16), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .ce(ce), .start(start),
    .genome1_size(genome1_size), .genome2_size(genome2_size),
    .sel(sel), .sel_ready(sel_ready),
    .g1_rd_addr(g1_rd_addr), .g2_rd_addr(g2_rd_addr),
    .g1_rd_data(g1_rd_data), .g2_rd_data(g2_rd_data),
    .child_wr_en(child_wr_en), .child_wr_addr(child_wr_addr), .child_wr_data(child_wr_data),
    .child_size(child_size), .busy(busy), .done(done), .err(err)
  );

  always @(posedge clk) begin
    if (ce) begin
      g1_rd_data <= g1_mem[g1_rd_addr];
      g2_rd_data <= g2_mem[g2_rd_addr];
    end
    if (rst && ce) begin
      if (child_wr_en) begin
        child_mem[child_wr_addr] <= child_wr_data;
        wr_cnt++;
      end
      if (done) done_cnt++;
      if (busy && !sel_ready && !done && !child_wr_en) rd_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mark();
    w0 = wr_cnt; d0 = done_cnt; r0 = rd_cnt;
  endtask

  task automatic do_start(input logic [7:0] s1, input logic [7:0] s2);
    genome1_size = s1; genome2_size = s2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_sel(input logic [1:0] v);
    int k = 0;
    while (!sel_ready && k < 20) begin @(negedge clk); k++; end
    if (!sel_ready) check_eq("sel_ready_timeout", 0, 1);
    sel = v;
    @(negedge clk);
    sel = 2'b00;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 2000) begin @(negedge clk); k++; end
    if (busy) check_eq("idle_timeout", 1, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      g1_mem[i] = 16'hA100 + 16'(i);
      g2_mem[i] = 16'hB000 + 16'(i);
      child_mem[i] = 16'h0;
    end
    rst = 1'b0; ce = 1'b1; start = 1'b0; sel = 2'b00;
    genome1_size = 8'd0; genome2_size = 8'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_sel_ready", sel_ready, 0);
    check_eq("rst_child_size", child_size, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_wr_en", child_wr_en, 0);
    rst = 1'b1;
    @(negedge clk);

    // Basic interleave 10,11,10,01
    mark();
    do_start(8'd3, 8'd3);
    check_eq("t1_busy", busy, 1);
    do_sel(2'b10); do_sel(2'b11); do_sel(2'b10); do_sel(2'b01);
    wait_idle();
    check_eq("t1_writes", wr_cnt - w0, 3);
    check_eq("t1_c0", child_mem[0], 16'hA100);
    check_eq("t1_c1", child_mem[1], 16'hB000);
    check_eq("t1_c2", child_mem[2], 16'hA101);
    check_eq("t1_size", child_size, 3);
    check_eq("t1_done", done_cnt - d0, 1);
    check_eq("t1_err", err, 0);

    // No-op selects then end
    mark();
    do_start(8'd3, 8'd3);
    repeat (5) @(negedge clk);
    check_eq("t2_ready", sel_ready, 1);
    do_sel(2'b01);
    wait_idle();
    check_eq("t2_writes", wr_cnt - w0, 0);
    check_eq("t2_size", child_size, 0);
    check_eq("t2_done", done_cnt - d0, 1);
    check_eq("t2_err", err, 0);

    // Exhausted parent 1
    mark();
    do_start(8'd1, 8'd3);
    do_sel(2'b10); do_sel(2'b10);
    wait_idle();
    check_eq("t3_writes", wr_cnt - w0, 1);
    check_eq("t3_reads", rd_cnt - r0, 1);
    check_eq("t3_err", err, 1);
    check_eq("t3_size", child_size, 1);
    check_eq("t3_done", done_cnt - d0, 1);

    // ce stall during READ
    mark();
    do_start(8'd2, 8'd2);
    do_sel(2'b11);
    check_eq("t4_addr", g2_rd_addr, 0);
    check_eq("t4_read_wr_en", child_wr_en, 0);
    ce = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("t4_frz_addr", g2_rd_addr, 0);
    check_eq("t4_frz_wr_en", child_wr_en, 0);
    check_eq("t4_frz_ready", sel_ready, 0);
    check_eq("t4_frz_busy", busy, 1);
    ce = 1'b1;
    @(negedge clk);
    check_eq("t4_wr_en", child_wr_en, 1);
    check_eq("t4_wr_addr", child_wr_addr, 0);
    check_eq("t4_wr_data", child_wr_data, 16'hB000);
    @(negedge clk);
    check_eq("t4_back_run", sel_ready, 1);
    do_sel(2'b01);
    wait_idle();
    check_eq("t4_writes", wr_cnt - w0, 1);
    check_eq("t4_size", child_size, 1);

    // Reset during WRITE
    mark();
    do_start(8'd2, 8'd2);
    do_sel(2'b10);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("t5_wr_en_drop", child_wr_en, 0);
    @(negedge clk);
    check_eq("t5_busy", busy, 0);
    check_eq("t5_size", child_size, 0);
    check_eq("t5_g1_addr", g1_rd_addr, 0);
    check_eq("t5_wr_data", child_wr_data, 0);
    check_eq("t5_writes", wr_cnt - w0, 0);
    rst = 1'b1;
    @(negedge clk);
    mark();
    do_start(8'd2, 8'd2);
    do_sel(2'b11); do_sel(2'b01);
    wait_idle();
    check_eq("t5b_writes", wr_cnt - w0, 1);
    check_eq("t5b_c0", child_mem[0], 16'hB000);
    check_eq("t5b_size", child_size, 1);

    // Saturation at 255
    mark();
    do_start(8'd255, 8'd1);
    for (int i = 0; i < 255; i++) do_sel(2'b10);
    do_sel(2'b11);
    wait_idle();
    check_eq("t6_writes", wr_cnt - w0, 256);
    check_eq("t6_c254", child_mem[254], 16'hA1FE);
    check_eq("t6_c255", child_mem[255], 16'hB000);
    check_eq("t6_size", child_size, 255);
    check_eq("t6_err", err, 1);
    check_eq("t6_done", done_cnt - d0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
